// File: rtl/risc_pkg.sv
// Shared constants for the single-cycle risc_core.
// Opcode encodings, instruction field positions and default widths.
package risc_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 32;
    localparam int REG_AW         = 5;

    localparam int OP_LSB  = 25;
    localparam int OP_W    = 7;
    localparam int DR_LSB  = 20;
    localparam int SA_LSB  = 15;
    localparam int SB_LSB  = 10;
    localparam int IMM_W   = 15;
    localparam int SH_W    = 5;

    localparam logic [OP_W-1:0] OP_NOP  = 7'b0000000;
    localparam logic [OP_W-1:0] OP_MOVA = 7'b1000000;
    localparam logic [OP_W-1:0] OP_MOVB = 7'b0001100;
    localparam logic [OP_W-1:0] OP_ADD  = 7'b0000010;
    localparam logic [OP_W-1:0] OP_SUB  = 7'b0000101;
    localparam logic [OP_W-1:0] OP_AND  = 7'b0001000;
    localparam logic [OP_W-1:0] OP_OR   = 7'b0001001;
    localparam logic [OP_W-1:0] OP_XOR  = 7'b0001010;
    localparam logic [OP_W-1:0] OP_NOT  = 7'b0001011;
    localparam logic [OP_W-1:0] OP_ADI  = 7'b0100010;
    localparam logic [OP_W-1:0] OP_SBI  = 7'b0100101;
    localparam logic [OP_W-1:0] OP_ANI  = 7'b0101000;
    localparam logic [OP_W-1:0] OP_ORI  = 7'b0101001;
    localparam logic [OP_W-1:0] OP_XRI  = 7'b0101010;
    localparam logic [OP_W-1:0] OP_LSR  = 7'b0001101;
    localparam logic [OP_W-1:0] OP_LSL  = 7'b0001110;
    localparam logic [OP_W-1:0] OP_LD   = 7'b0010000;
    localparam logic [OP_W-1:0] OP_ST   = 7'b0100000;
    localparam logic [OP_W-1:0] OP_SLT  = 7'b1100101;
    localparam logic [OP_W-1:0] OP_JMR  = 7'b1110000;
    localparam logic [OP_W-1:0] OP_BZ   = 7'b1100000;
    localparam logic [OP_W-1:0] OP_BNZ  = 7'b1001000;
    localparam logic [OP_W-1:0] OP_JMP  = 7'b1101000;
    localparam logic [OP_W-1:0] OP_JML  = 7'b0110000;
    localparam logic [OP_W-1:0] OP_HALT = 7'b1111111;

endpackage

// File: rtl/risc_regfile.sv
// 32-entry register file: two async read ports, one sync write port,
// every entry exposed for observation.
module risc_regfile
    import risc_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DW-1:0]     wd,
    input  logic [REG_AW-1:0] ra_a,
    input  logic [REG_AW-1:0] ra_b,
    output logic [DW-1:0]     rd_a,
    output logic [DW-1:0]     rd_b,
    output logic [DW-1:0]     regs [NUM_REGS]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];

endmodule

// File: rtl/risc_core.sv
// Single-cycle load/store RISC core with internal IMEM/DMEM.
// One instruction retires per enabled clock until HALT.
module risc_core
    import risc_pkg::*;
#(
    parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int    ADDR_DEPTH   = 2048,
    parameter string PROGRAM_CODE = "prog-bin.dat",
    parameter string PROGRAM_DATA = "prog-data.dat"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  halt,
    output logic [DATA_WIDTH-1:0] reg0,
    output logic [DATA_WIDTH-1:0] reg1,
    output logic [DATA_WIDTH-1:0] reg2,
    output logic [DATA_WIDTH-1:0] reg3,
    output logic [DATA_WIDTH-1:0] reg4,
    output logic [DATA_WIDTH-1:0] reg5,
    output logic [DATA_WIDTH-1:0] reg6,
    output logic [DATA_WIDTH-1:0] reg7,
    output logic [DATA_WIDTH-1:0] reg8,
    output logic [DATA_WIDTH-1:0] reg9,
    output logic [DATA_WIDTH-1:0] reg10,
    output logic [DATA_WIDTH-1:0] reg11,
    output logic [DATA_WIDTH-1:0] reg12,
    output logic [DATA_WIDTH-1:0] reg13,
    output logic [DATA_WIDTH-1:0] reg14,
    output logic [DATA_WIDTH-1:0] reg15,
    output logic [DATA_WIDTH-1:0] reg16,
    output logic [DATA_WIDTH-1:0] reg17,
    output logic [DATA_WIDTH-1:0] reg18,
    output logic [DATA_WIDTH-1:0] reg19,
    output logic [DATA_WIDTH-1:0] reg20,
    output logic [DATA_WIDTH-1:0] reg21,
    output logic [DATA_WIDTH-1:0] reg22,
    output logic [DATA_WIDTH-1:0] reg23,
    output logic [DATA_WIDTH-1:0] reg24,
    output logic [DATA_WIDTH-1:0] reg25,
    output logic [DATA_WIDTH-1:0] reg26,
    output logic [DATA_WIDTH-1:0] reg27,
    output logic [DATA_WIDTH-1:0] reg28,
    output logic [DATA_WIDTH-1:0] reg29,
    output logic [DATA_WIDTH-1:0] reg30,
    output logic [DATA_WIDTH-1:0] reg31
);

    localparam int AW = $clog2(ADDR_DEPTH);

    logic [DATA_WIDTH-1:0] imem [ADDR_DEPTH];
    logic [DATA_WIDTH-1:0] dmem [ADDR_DEPTH];

    logic [AW-1:0]         pc;
    logic [AW-1:0]         pc_inc;
    logic [AW-1:0]         pc_next;
    logic [AW-1:0]         br_tgt;
    logic [DATA_WIDTH-1:0] instr;
    logic [OP_W-1:0]       op;
    logic [REG_AW-1:0]     dr;
    logic [REG_AW-1:0]     sa;
    logic [REG_AW-1:0]     sb;
    logic [IMM_W-1:0]      imm;
    logic [SH_W-1:0]       sh;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_z;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  rf_we;
    logic                  dm_we;
    logic                  halt_set;
    logic                  step;

    assign instr = imem[pc];
    assign op    = instr[OP_LSB +: OP_W];
    assign dr    = instr[DR_LSB +: REG_AW];
    assign sa    = instr[SA_LSB +: REG_AW];
    assign sb    = instr[SB_LSB +: REG_AW];
    assign imm   = instr[IMM_W-1:0];
    assign sh    = instr[SH_W-1:0];
    assign imm_s = {{(DATA_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_z = {{(DATA_WIDTH-IMM_W){1'b0}}, imm};

    assign pc_inc = pc + 1'b1;
    assign br_tgt = pc_inc + imm_s[AW-1:0];
    assign step   = en && !halt;

    risc_regfile #(.DW(DATA_WIDTH)) u_rf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (rf_we && step),
        .wa   (dr),
        .wd   (wd),
        .ra_a (sa),
        .ra_b (sb),
        .rd_a (rd_a),
        .rd_b (rd_b),
        .regs (regs)
    );

    always_comb begin
        wd       = '0;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        halt_set = 1'b0;
        pc_next  = pc_inc;
        unique case (op)
            OP_MOVA: begin rf_we = 1'b1; wd = rd_a; end
            OP_MOVB: begin rf_we = 1'b1; wd = rd_b; end
            OP_ADD:  begin rf_we = 1'b1; wd = rd_a + rd_b; end
            OP_SUB:  begin rf_we = 1'b1; wd = rd_a - rd_b; end
            OP_AND:  begin rf_we = 1'b1; wd = rd_a & rd_b; end
            OP_OR:   begin rf_we = 1'b1; wd = rd_a | rd_b; end
            OP_XOR:  begin rf_we = 1'b1; wd = rd_a ^ rd_b; end
            OP_NOT:  begin rf_we = 1'b1; wd = ~rd_a; end
            OP_ADI:  begin rf_we = 1'b1; wd = rd_a + imm_s; end
            OP_SBI:  begin rf_we = 1'b1; wd = rd_a - imm_s; end
            OP_ANI:  begin rf_we = 1'b1; wd = rd_a & imm_z; end
            OP_ORI:  begin rf_we = 1'b1; wd = rd_a | imm_z; end
            OP_XRI:  begin rf_we = 1'b1; wd = rd_a ^ imm_z; end
            OP_LSR:  begin rf_we = 1'b1; wd = rd_a >> sh; end
            OP_LSL:  begin rf_we = 1'b1; wd = rd_a << sh; end
            OP_LD:   begin rf_we = 1'b1; wd = dmem[rd_a[AW-1:0]]; end
            OP_ST:   dm_we = 1'b1;
            OP_SLT: begin
                rf_we = 1'b1;
                wd    = {{(DATA_WIDTH-1){1'b0}},
                         ($signed(rd_a) < $signed(rd_b))};
            end
            OP_JMR:  pc_next = rd_a[AW-1:0];
            OP_BZ:   if (rd_a == '0) pc_next = br_tgt;
            OP_BNZ:  if (rd_a != '0) pc_next = br_tgt;
            OP_JMP:  pc_next = br_tgt;
            OP_JML: begin
                rf_we   = 1'b1;
                wd      = {{(DATA_WIDTH-AW){1'b0}}, pc_inc};
                pc_next = br_tgt;
            end
            OP_HALT: begin pc_next = pc; halt_set = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= '0;
            halt <= 1'b0;
        end else if (step) begin
            pc <= pc_next;
            if (halt_set) halt <= 1'b1;
        end
    end

    // rst_n gate drops a store landing on the edge where reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && step && dm_we) dmem[rd_a[AW-1:0]] <= rd_b;
    end

    assign reg0  = regs[0];
    assign reg1  = regs[1];
    assign reg2  = regs[2];
    assign reg3  = regs[3];
    assign reg4  = regs[4];
    assign reg5  = regs[5];
    assign reg6  = regs[6];
    assign reg7  = regs[7];
    assign reg8  = regs[8];
    assign reg9  = regs[9];
    assign reg10 = regs[10];
    assign reg11 = regs[11];
    assign reg12 = regs[12];
    assign reg13 = regs[13];
    assign reg14 = regs[14];
    assign reg15 = regs[15];
    assign reg16 = regs[16];
    assign reg17 = regs[17];
    assign reg18 = regs[18];
    assign reg19 = regs[19];
    assign reg20 = regs[20];
    assign reg21 = regs[21];
    assign reg22 = regs[22];
    assign reg23 = regs[23];
    assign reg24 = regs[24];
    assign reg25 = regs[25];
    assign reg26 = regs[26];
    assign reg27 = regs[27];
    assign reg28 = regs[28];
    assign reg29 = regs[29];
    assign reg30 = regs[30];
    assign reg31 = regs[31];

endmodule

// File: tb/tb_risc_core.sv
// Bench for risc_core: instruction-level reference model feeds a queue of
// expected architectural state, a monitor compares after every edge.
module tb_risc_core;

    localparam logic [6:0] O_MOVA = 7'b1000000, O_MOVB = 7'b0001100;
    localparam logic [6:0] O_ADD  = 7'b0000010, O_SUB  = 7'b0000101;
    localparam logic [6:0] O_AND  = 7'b0001000, O_OR   = 7'b0001001;
    localparam logic [6:0] O_XOR  = 7'b0001010, O_NOT  = 7'b0001011;
    localparam logic [6:0] O_ADI  = 7'b0100010, O_SBI  = 7'b0100101;
    localparam logic [6:0] O_ANI  = 7'b0101000, O_ORI  = 7'b0101001;
    localparam logic [6:0] O_XRI  = 7'b0101010, O_LSR  = 7'b0001101;
    localparam logic [6:0] O_LSL  = 7'b0001110, O_LD   = 7'b0010000;
    localparam logic [6:0] O_ST   = 7'b0100000, O_SLT  = 7'b1100101;
    localparam logic [6:0] O_JMR  = 7'b1110000, O_BZ   = 7'b1100000;
    localparam logic [6:0] O_BNZ  = 7'b1001000, O_JMP  = 7'b1101000;
    localparam logic [6:0] O_JML  = 7'b0110000, O_HLT  = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        halt;
    logic [31:0] r [32];

    always #5 clk = ~clk;

    risc_core dut (
        .clk(clk), .rst_n(rst_n), .en(en), .halt(halt),
        .reg0(r[0]),   .reg1(r[1]),   .reg2(r[2]),   .reg3(r[3]),
        .reg4(r[4]),   .reg5(r[5]),   .reg6(r[6]),   .reg7(r[7]),
        .reg8(r[8]),   .reg9(r[9]),   .reg10(r[10]), .reg11(r[11]),
        .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
        .reg16(r[16]), .reg17(r[17]), .reg18(r[18]), .reg19(r[19]),
        .reg20(r[20]), .reg21(r[21]), .reg22(r[22]), .reg23(r[23]),
        .reg24(r[24]), .reg25(r[25]), .reg26(r[26]), .reg27(r[27]),
        .reg28(r[28]), .reg29(r[29]), .reg30(r[30]), .reg31(r[31])
    );

    logic [31:0]   prog [2048];
    logic [31:0]   mr   [32];
    logic [31:0]   mm   [2048];
    int            mpc;
    bit            mh;
    int            pw;
    logic [1024:0] q [$];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [31:0] ri(logic [6:0] op, int d, int a, int b);
        return {op, 5'(d), 5'(a), 5'(b), 10'd0};
    endfunction

    function automatic logic [31:0] ii(logic [6:0] op, int d, int a, int imm);
        return {op, 5'(d), 5'(a), 15'(imm)};
    endfunction

    task automatic put(input logic [31:0] w);
        prog[pw] = w;
        pw++;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) prog[i] = '0;
        pw = 0;
    endtask

    task automatic model_reset();
        mpc = 0;
        mh  = 0;
        for (int i = 0; i < 32; i++) mr[i] = '0;
    endtask

    // Executes the instruction at mpc straight from the opcode table.
    task automatic model_step();
        logic [31:0] ins, a, b, se, ze;
        logic [6:0]  op;
        int          d, nxt, off;
        ins = prog[mpc];
        op  = ins[31:25];
        d   = int'(ins[24:20]);
        a   = mr[ins[19:15]];
        b   = mr[ins[14:10]];
        off = int'(ins[14:0]);
        if (off >= 16384) off -= 32768;
        se  = 32'(off);
        ze  = {17'd0, ins[14:0]};
        nxt = (mpc + 1) % 2048;
        case (op)
            O_MOVA: mr[d] = a;
            O_MOVB: mr[d] = b;
            O_ADD:  mr[d] = a + b;
            O_SUB:  mr[d] = a - b;
            O_AND:  mr[d] = a & b;
            O_OR:   mr[d] = a | b;
            O_XOR:  mr[d] = a ^ b;
            O_NOT:  mr[d] = ~a;
            O_ADI:  mr[d] = a + se;
            O_SBI:  mr[d] = a - se;
            O_ANI:  mr[d] = a & ze;
            O_ORI:  mr[d] = a | ze;
            O_XRI:  mr[d] = a ^ ze;
            O_LSR:  mr[d] = a >> ins[4:0];
            O_LSL:  mr[d] = a << ins[4:0];
            O_LD:   mr[d] = mm[int'(a % 2048)];
            O_ST:   mm[int'(a % 2048)] = b;
            O_SLT:  mr[d] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            O_JMR:  nxt = int'(a % 2048);
            O_BZ:   if (a == 0) nxt = (mpc + 1 + off) & 2047;
            O_BNZ:  if (a != 0) nxt = (mpc + 1 + off) & 2047;
            O_JMP:  nxt = (mpc + 1 + off) & 2047;
            O_JML: begin
                mr[d] = 32'(nxt);
                nxt   = (mpc + 1 + off) & 2047;
            end
            O_HLT: begin mh = 1; nxt = mpc; end
            default: ;
        endcase
        mpc = nxt;
    endtask

    function automatic logic [1024:0] snap();
        logic [1024:0] v;
        for (int k = 0; k < 32; k++) v[k*32 +: 32] = mr[k];
        v[1024] = mh;
        return v;
    endfunction

    task automatic tick(input bit rn, input int pct);
        @(negedge clk);
        rst_n = rn;
        en    = ($urandom_range(99) < pct);
        if (!rn) model_reset();
        else if (en && !mh) model_step();
        q.push_back(snap());
    endtask

    task automatic run(input int max_cyc, input int pct, input int rst_at);
        int extra = 0;
        tick(0, 50);
        for (int i = 0; i < 2048; i++) dut.imem[i] = prog[i];
        tick(0, 50);
        for (int c = 0; c < max_cyc && extra < 4; c++) begin
            if (c == rst_at) begin
                tick(0, 50);
                tick(0, 50);
            end
            tick(1, pct);
            if (mh) extra++;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [24];
        logic [6:0] op;
        int         d, a, b, imm;
        ops = '{O_MOVA, O_MOVB, O_ADD, O_SUB, O_AND, O_OR, O_XOR, O_NOT,
                O_ADI, O_SBI, O_ANI, O_ORI, O_XRI, O_LSR, O_LSL, O_LD,
                O_ST, O_SLT, O_BZ, O_BNZ, O_JMP, O_JML, O_JMR, 7'b0};
        op = ops[$urandom_range(23)];
        if (op == 7'b0) op = 7'($urandom_range(126));
        d   = $urandom_range(7);
        a   = $urandom_range(7);
        b   = $urandom_range(7);
        imm = int'($urandom_range(32767));
        if (op inside {O_BZ, O_BNZ, O_JMP, O_JML})
            imm = int'($urandom_range(10)) - 5;
        if (op == O_JMR) a = 0;
        return {op, 5'(d), 5'(a), 15'(imm)};
    endfunction

    initial begin : monitor
        logic [1024:0] e;
        int            bad;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (halt !== e[1024]) begin
                    errors++;
                    $display("FAIL halt: got %0b want %0b", halt, e[1024]);
                end
                checks++;
                bad = -1;
                for (int k = 31; k >= 0; k--)
                    if (r[k] !== e[k*32 +: 32]) bad = k;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL reg%0d: got %h want %h @%0t",
                             bad, r[bad], e[bad*32 +: 32], $time);
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 2048; i++) mm[i] = '0;
        model_reset();

        clear_prog();
        put(ii(O_HLT, 0, 0, 0));
        put(ii(O_ADI, 1, 0, 5));
        run(12, 60, -1);

        clear_prog();
        put(ri(O_ST, 0, 1, 0));
        put(ii(O_ADI, 1, 1, 1));
        put(ii(O_SBI, 2, 1, 2048));
        put(ii(O_BNZ, 0, 2, -4));
        put(ii(O_HLT, 0, 0, 0));
        run(15000, 85, -1);

        clear_prog();
        put(ii(O_ADI, 1, 0, 5));
        put(ii(O_ADI, 2, 0, 3));
        put(ri(O_SUB, 3, 1, 2));
        put(ii(O_SBI, 4, 0, 1));
        put(ii(O_HLT, 0, 0, 0));
        run(40, 70, -1);

        clear_prog();
        put(ii(O_ADI, 1, 0, 10));
        put(ii(O_ADI, 9, 0, 7));
        put(ri(O_ST, 0, 1, 9));
        put(ri(O_LD, 2, 1, 0));
        put(ii(O_ADI, 3, 2, 1));
        put(ri(O_ST, 0, 1, 3));
        put(ri(O_LD, 4, 1, 0));
        put(ii(O_ADI, 4, 4, 1));
        put(ii(O_ADI, 5, 0, 2058));
        put(ri(O_LD, 6, 5, 0));
        put(ii(O_HLT, 0, 0, 0));
        run(60, 70, -1);

        clear_prog();
        put(ii(O_BZ, 0, 1, 1));
        put(ii(O_ADI, 5, 0, 9));
        put(ii(O_BNZ, 0, 1, 1));
        put(ii(O_ADI, 6, 0, 4));
        put(ii(O_ADI, 7, 7, 1));
        put(ii(O_SBI, 8, 7, 3));
        put(ii(O_BZ, 0, 8, 1));
        put(ii(O_JML, 31, 0, -4));
        put(ii(O_JMP, 0, 0, 2));
        put(ii(O_ADI, 9, 0, 1));
        put(ii(O_ADI, 9, 0, 2));
        put(ii(O_HLT, 0, 0, 0));
        run(80, 70, -1);

        clear_prog();
        put(ii(O_SBI, 1, 0, 1));
        put(ii(O_ADI, 2, 0, 1));
        put(ri(O_SLT, 3, 1, 2));
        put(ri(O_SLT, 4, 2, 1));
        put(ii(O_LSL, 6, 2, 4));
        put(ii(O_LSR, 7, 1, 28));
        put(ii(O_ADI, 8, 0, 32767));
        put(ii(O_ORI, 9, 0, 32767));
        put(ii(O_XRI, 10, 1, 21845));
        put(ii(O_ANI, 11, 1, 16384));
        put(ri(O_NOT, 12, 6, 0));
        put(ri(O_MOVA, 13, 7, 0));
        put(ri(O_MOVB, 14, 0, 6));
        put(ri(O_AND, 15, 10, 9));
        put(ri(O_OR, 16, 6, 7));
        put(ri(O_XOR, 17, 1, 10));
        put(ri(O_ADD, 18, 1, 1));
        put(ii(O_HLT, 0, 0, 0));
        run(80, 70, -1);

        clear_prog();
        put(ii(O_BNZ, 0, 2, 2));
        put(ii(O_ADI, 1, 0, 2047));
        put(ri(O_JMR, 0, 1, 0));
        put(ii(O_SBI, 5, 2, 2));
        put(ii(O_BZ, 0, 5, 1));
        put(ii(O_JML, 4, 0, -7));
        put(ii(O_HLT, 0, 0, 0));
        prog[2047] = ii(O_ADI, 2, 2, 1);
        run(60, 70, -1);

        for (int p = 0; p < 8; p++) begin
            clear_prog();
            for (int i = 0; i < 30; i++) put(rand_instr());
            put(ii(O_HLT, 0, 0, 0));
            run(200, 65, (p == 3) ? 17 : -1);
        end

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
